// File: rtl/spi_pkg.sv
// Shared SPI definitions for the FIR-over-SPI prototype (initiator and slave).
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    GAP
  } spi_state_e;

  localparam int unsigned SPI_DATA_W = 16;
  localparam logic        SPI_CPOL   = 1'b0;
  localparam logic        SPI_CPHA   = 1'b0;

endpackage

// File: rtl/spi_clk_div.sv
// Free-running divider with synchronous clear; tick is high on the terminal count cycle.
module spi_clk_div #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic n_rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = en && (cnt == W'(DIV - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 initiator: one start pulse runs a full-duplex DATA_W-bit frame, MSB first,
// with nss lead, trail and inter-frame gap of CLK_DIV cycles each.
module spi_master_tx
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W  = SPI_DATA_W,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              miso,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sck,
  output logic              mosi,
  output logic              nss
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  generate
    if (CLK_DIV < 4) begin : g_clk_div_chk
      $error("spi_master_tx: CLK_DIV must be >= 4");
    end
    if (DATA_W < 2) begin : g_data_w_chk
      $error("spi_master_tx: DATA_W must be >= 2");
    end
  endgenerate

  spi_state_e        state, state_n;
  logic [DATA_W-1:0] tx_shift, tx_shift_n;
  logic [DATA_W-1:0] rx_shift, rx_shift_n;
  logic [DATA_W-1:0] rx_data_n;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
  logic              sck_n, mosi_n, nss_n, busy_n, done_n;
  logic              tick, launch;

  // Every state transition happens on a tick, so the divider wrap doubles as
  // its reset-on-entry; it is only held clear while idle.
  spi_clk_div #(.DIV(CLK_DIV)) u_clk_div (
    .clk   (clk),
    .n_rst (n_rst),
    .en    (state != IDLE),
    .clr   (state == IDLE),
    .tick  (tick)
  );

  // A start on the gap's final edge is the same edge as the done pulse, which
  // keeps the back-to-back nss-high time at exactly CLK_DIV cycles.
  assign launch = start && ((state == IDLE) || ((state == GAP) && tick));

  always_comb begin
    state_n    = state;
    tx_shift_n = tx_shift;
    rx_shift_n = rx_shift;
    rx_data_n  = rx_data;
    bit_cnt_n  = bit_cnt;
    sck_n      = sck;
    mosi_n     = mosi;
    nss_n      = nss;
    busy_n     = busy;
    done_n     = 1'b0;

    case (state)
      SETUP: begin
        if (tick) begin
          sck_n      = 1'b1;
          rx_shift_n = {rx_shift[DATA_W-2:0], miso};
          state_n    = XFER;
        end
      end
      XFER: begin
        if (tick) begin
          if (sck) begin
            sck_n      = 1'b0;
            tx_shift_n = tx_shift << 1;
            bit_cnt_n  = bit_cnt + 1'b1;
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              state_n = HOLD;
            end else begin
              mosi_n = tx_shift[DATA_W-2];
            end
          end else begin
            sck_n      = 1'b1;
            rx_shift_n = {rx_shift[DATA_W-2:0], miso};
          end
        end
      end
      HOLD: begin
        if (tick) begin
          nss_n   = 1'b1;
          mosi_n  = 1'b0;
          state_n = GAP;
        end
      end
      GAP: begin
        if (tick) begin
          rx_data_n = rx_shift;
          done_n    = 1'b1;
          busy_n    = 1'b0;
          state_n   = IDLE;
        end
      end
      default: ;
    endcase

    if (launch) begin
      state_n    = SETUP;
      tx_shift_n = tx_data;
      nss_n      = 1'b0;
      mosi_n     = tx_data[DATA_W-1];
      busy_n     = 1'b1;
      bit_cnt_n  = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      bit_cnt  <= '0;
      sck      <= SPI_CPOL;
      mosi     <= 1'b0;
      nss      <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      tx_shift <= tx_shift_n;
      rx_shift <= rx_shift_n;
      rx_data  <= rx_data_n;
      bit_cnt  <= bit_cnt_n;
      sck      <= sck_n;
      mosi     <= mosi_n;
      nss      <= nss_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_spi_master_tx.sv
// Self-checking bench for spi_master_tx: edge-indexed frame observation plus an rx scoreboard.
module tb_spi_master_tx;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] tx_data = '0;
  logic        miso = 1'b0;
  logic        busy, done, sck, mosi, nss;
  logic [15:0] rx_data;

  spi_master_tx #(.DATA_W(16), .CLK_DIV(4)) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .start   (start),
    .tx_data (tx_data),
    .miso    (miso),
    .busy    (busy),
    .done    (done),
    .rx_data (rx_data),
    .sck     (sck),
    .mosi    (mosi),
    .nss     (nss)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] sb_q[$];
  int          rise_edges[$];
  logic        mosi_rises[$];
  int          nss_rise_edges[$];
  int          nss_fall_edges[$];
  int          done_edges[$];
  logic [15:0] got_rx[$];
  logic [15:0] exp_rx[$];
  int          last_fall;
  int          mosi_hi_chg;
  int          busy_first_low;
  logic        loopback = 1'b1;
  logic [15:0] slave_word = '0;
  int          slave_idx = 15;
  logic        rst_nss, rst_sck, rst_busy, rst_done;
  logic [15:0] rst_rx;

  // Starts a frame on the next posedge (edge 0) and records events for edges 0..n_edges-1.
  task automatic run_frame(input logic [15:0] data, input logic [15:0] expect_rx,
                           input bit hold, input int stop_hold, input int p1, input int p2,
                           input int rst_edge, input int n_edges);
    logic p_sck, p_mosi, p_nss;
    rise_edges.delete(); mosi_rises.delete(); nss_rise_edges.delete();
    nss_fall_edges.delete(); done_edges.delete(); got_rx.delete(); exp_rx.delete();
    last_fall = -1; mosi_hi_chg = 0; busy_first_low = -1;
    slave_idx = 15;
    tx_data = data;
    start = 1'b1;
    miso = loopback ? data[15] : slave_word[15];
    p_sck = sck; p_mosi = mosi; p_nss = nss;
    for (int n = 0; n < n_edges; n++) begin
      @(negedge clk);
      if (p_nss && !nss) begin
        nss_fall_edges.push_back(n);
        sb_q.push_back(expect_rx);
        slave_idx = 15;
      end
      if (!p_nss && nss) nss_rise_edges.push_back(n);
      if (sck && !p_sck) begin
        rise_edges.push_back(n);
        mosi_rises.push_back(mosi);
      end
      if (!sck && p_sck) begin
        last_fall = n;
        if (slave_idx > 0) slave_idx--;
      end
      if (sck && (mosi !== p_mosi)) mosi_hi_chg++;
      if (!busy && busy_first_low < 0) busy_first_low = n;
      if (done) begin
        done_edges.push_back(n);
        got_rx.push_back(rx_data);
        if (sb_q.size() > 0) exp_rx.push_back(sb_q.pop_front());
        else exp_rx.push_back(16'hDEAD);
      end
      p_sck = sck; p_mosi = mosi; p_nss = nss;
      miso = loopback ? mosi : slave_word[slave_idx];
      if (hold && (n + 1 < stop_hold)) start = 1'b1;
      else start = ((n + 1) == p1) || ((n + 1) == p2);
      if (n == rst_edge - 1) begin
        n_rst = 1'b0;
        #1;
        rst_nss = nss; rst_sck = sck; rst_busy = busy; rst_done = done; rst_rx = rx_data;
      end
      if (n == rst_edge + 1) n_rst = 1'b1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (sck !== 1'b0)      begin errors++; $display("FAIL reset_sck: got %b expected 0", sck); end
    checks++; if (nss !== 1'b1)      begin errors++; $display("FAIL reset_nss: got %b expected 1", nss); end
    checks++; if (mosi !== 1'b0)     begin errors++; $display("FAIL reset_mosi: got %b expected 0", mosi); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (rx_data !== 16'h0) begin errors++; $display("FAIL reset_rx: got %h expected 0000", rx_data); end
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_loopback();
    loopback = 1'b1;
    run_frame(16'hA5C3, 16'hA5C3, 0, 0, -1, -1, -1, 150);
    checks++; if (rise_edges.size() != 16) begin errors++; $display("FAIL lb_rises: got %0d expected 16", rise_edges.size()); end
    checks++; if (rise_edges.size() == 0 || rise_edges[0] != 4) begin errors++; $display("FAIL lb_first_rise: got %0d expected 4", rise_edges.size() ? rise_edges[0] : -1); end
    checks++; if (last_fall != 128) begin errors++; $display("FAIL lb_last_fall: got %0d expected 128", last_fall); end
    checks++; if (nss_rise_edges.size() != 1 || nss_rise_edges[0] != 132) begin errors++; $display("FAIL lb_nss_rise: got %0d expected 132", nss_rise_edges.size() ? nss_rise_edges[0] : -1); end
    checks++; if (done_edges.size() != 1 || done_edges[0] != 136) begin errors++; $display("FAIL lb_done_edge: got %0d (count %0d) expected 136", done_edges.size() ? done_edges[0] : -1, done_edges.size()); end
    checks++; if (busy_first_low != 136) begin errors++; $display("FAIL lb_busy_span: busy first low at edge %0d expected 136", busy_first_low); end
    checks++; if (got_rx.size() != 1 || got_rx[0] !== exp_rx[0] || got_rx[0] !== 16'hA5C3) begin errors++; $display("FAIL lb_rx: got %h expected %h", got_rx.size() ? got_rx[0] : 16'h0, 16'hA5C3); end
  endtask

  task automatic test_mosi_pattern();
    logic [15:0] d;
    d = 16'h8001;
    loopback = 1'b1;
    run_frame(d, d, 0, 0, -1, -1, -1, 150);
    checks++; if (mosi_rises.size() != 16) begin errors++; $display("FAIL pat_rises: got %0d expected 16", mosi_rises.size()); end
    for (int i = 0; i < 16 && i < mosi_rises.size(); i++) begin
      checks++;
      if (mosi_rises[i] !== d[15-i]) begin errors++; $display("FAIL pat_bit%0d: got %b expected %b", i, mosi_rises[i], d[15-i]); end
    end
    checks++; if (mosi_hi_chg != 0) begin errors++; $display("FAIL pat_mosi_stable: got %0d changes while sck high expected 0", mosi_hi_chg); end
  endtask

  task automatic test_slave_rx();
    loopback = 1'b0;
    slave_word = 16'h3C5A;
    run_frame(16'hFFFF, 16'h3C5A, 0, 0, -1, -1, -1, 150);
    loopback = 1'b1;
    checks++; if (done_edges.size() != 1) begin errors++; $display("FAIL slv_done_count: got %0d expected 1", done_edges.size()); end
    checks++; if (got_rx.size() == 0 || got_rx[0] !== exp_rx[0] || got_rx[0] !== 16'h3C5A) begin errors++; $display("FAIL slv_rx: got %h expected 3c5a", got_rx.size() ? got_rx[0] : 16'h0); end
  endtask

  task automatic test_start_ignored();
    loopback = 1'b1;
    run_frame(16'h5AA5, 16'h5AA5, 0, 0, 20, 60, -1, 160);
    checks++; if (rise_edges.size() != 16) begin errors++; $display("FAIL ign_rises: got %0d expected 16", rise_edges.size()); end
    checks++; if (done_edges.size() != 1) begin errors++; $display("FAIL ign_done_count: got %0d expected 1", done_edges.size()); end
    checks++; if (nss_fall_edges.size() != 1) begin errors++; $display("FAIL ign_frames: got %0d expected 1", nss_fall_edges.size()); end
    checks++; if (got_rx.size() == 0 || got_rx[0] !== exp_rx[0]) begin errors++; $display("FAIL ign_rx: got %h expected %h", got_rx.size() ? got_rx[0] : 16'h0, exp_rx.size() ? exp_rx[0] : 16'h0); end
  endtask

  task automatic test_back_to_back();
    loopback = 1'b1;
    run_frame(16'h1234, 16'h1234, 1, 200, -1, -1, -1, 290);
    checks++; if (nss_fall_edges.size() != 2 || nss_rise_edges.size() < 1 || nss_fall_edges[1] - nss_rise_edges[0] != 4) begin errors++; $display("FAIL b2b_gap: got %0d frames, gap %0d expected 2 frames gap 4", nss_fall_edges.size(), (nss_fall_edges.size() > 1 && nss_rise_edges.size() > 0) ? nss_fall_edges[1] - nss_rise_edges[0] : -1); end
    checks++; if (rise_edges.size() != 32 || rise_edges[16] != 140) begin errors++; $display("FAIL b2b_second_rise: got %0d (rises %0d) expected 140", rise_edges.size() > 16 ? rise_edges[16] : -1, rise_edges.size()); end
    checks++; if (done_edges.size() != 2 || done_edges[1] != 272) begin errors++; $display("FAIL b2b_done: got count %0d expected 2 with second at 272", done_edges.size()); end
    for (int i = 0; i < 2 && i < got_rx.size(); i++) begin
      checks++;
      if (got_rx[i] !== exp_rx[i] || got_rx[i] !== 16'h1234) begin errors++; $display("FAIL b2b_rx%0d: got %h expected 1234", i, got_rx[i]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    loopback = 1'b1;
    run_frame(16'hBEEF, 16'hBEEF, 0, 0, -1, -1, 50, 80);
    checks++; if (rst_nss !== 1'b1)  begin errors++; $display("FAIL rst_nss: got %b expected 1", rst_nss); end
    checks++; if (rst_sck !== 1'b0)  begin errors++; $display("FAIL rst_sck: got %b expected 0", rst_sck); end
    checks++; if (rst_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", rst_busy); end
    checks++; if (rst_rx !== 16'h0 || rst_done !== 1'b0) begin errors++; $display("FAIL rst_rx: got %h done %b expected 0000 done 0", rst_rx, rst_done); end
    checks++; if (done_edges.size() != 0) begin errors++; $display("FAIL rst_no_done: got %0d done pulses expected 0", done_edges.size()); end
    sb_q.delete();
    repeat (2) @(negedge clk);
    run_frame(16'h00FF, 16'h00FF, 0, 0, -1, -1, -1, 150);
    checks++; if (done_edges.size() != 1 || done_edges[0] != 136) begin errors++; $display("FAIL rst_after_done: got count %0d expected 1 at 136", done_edges.size()); end
    checks++; if (got_rx.size() == 0 || got_rx[0] !== exp_rx[0] || got_rx[0] !== 16'h00FF) begin errors++; $display("FAIL rst_after_rx: got %h expected 00ff", got_rx.size() ? got_rx[0] : 16'h0); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    repeat (3) @(negedge clk);
    test_mosi_pattern();
    repeat (3) @(negedge clk);
    test_slave_rx();
    repeat (3) @(negedge clk);
    test_start_ignored();
    repeat (3) @(negedge clk);
    test_back_to_back();
    repeat (3) @(negedge clk);
    test_reset_mid_frame();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_tx.md
Name: spi_master_tx

Overview:
SPI initiator (mode 0: CPOL=0, CPHA=0, MSB first) that drives sck/mosi/nss toward the team's SPI slave receive path and captures miso. A single start pulse launches a DATA_W-bit full-duplex frame. Frame timing gives the slave's 2-FF input synchronizers enough margin to detect the nss fall and each sck edge. Sits in the SoC-side test/host wrapper of the FIR-over-SPI prototype.

Parameters:
DATA_W, 16, frame length in bits (>=2)
CLK_DIV, 4, sck half-period in clk cycles; elaboration-time assertion CLK_DIV >= 4 (slave sync + edge-detect latency)

Ports:
clk  in  1  system clock
n_rst  in  1  reset, asynchronous, active-low
start  in  1  launch request; sampled only in IDLE
tx_data  in  DATA_W  word to send; captured on accepted start
miso  in  1  serial data from slave
busy  out  1  high from accepted start until done cycle
done  out  1  one-cycle pulse; rx_data valid in the same cycle
rx_data  out  DATA_W  last received word; holds until next done
sck  out  1  SPI clock, idle low
mosi  out  1  serial data to slave
nss  out  1  slave select, active-low

Behaviour:
- Reset values (async): sck=0, nss=1, mosi=0, busy=0, done=0, rx_data=0, state IDLE, counters 0.
- All outputs are registered; no combinational path from start to the SPI pins.
- Timing is given in clk edges relative to edge 0, the edge that samples start=1 in IDLE.
- Edge 0: capture tx_data into tx_shift; nss=0; mosi=tx_data[DATA_W-1]; busy=1; enter SETUP.
- SETUP: lasts CLK_DIV cycles (nss-to-sck lead). At edge CLK_DIV: sck=1, enter XFER.
- XFER: a divider tick every CLK_DIV cycles toggles sck.
  - Rising ticks at edges CLK_DIV*(1+2k), k=0..DATA_W-1: rx_shift <= {rx_shift[DATA_W-2:0], miso}.
  - Falling ticks at edges CLK_DIV*(2+2k): sck=0 and tx_shift shifts left. For k<DATA_W-1, mosi takes the next bit, so each bit is stable one full sck period, centred on its rising edge.
  - The last fall, at edge 2*DATA_W*CLK_DIV, enters HOLD; mosi holds the LSB.
- HOLD: sck=0, nss=0 for CLK_DIV cycles. At edge (2*DATA_W+1)*CLK_DIV: nss=1, mosi=0, enter GAP.
- GAP: nss high for CLK_DIV cycles. At edge (2*DATA_W+2)*CLK_DIV: rx_data<=rx_shift; done=1 for one cycle; busy=0; enter IDLE.
- start is ignored in SETUP/XFER/HOLD/GAP and is not queued.
- The done cycle is in IDLE, so start high on the done edge is accepted. Minimum nss-high gap between frames is therefore CLK_DIV cycles.
- tx_data changes after capture have no effect. miso is sampled raw on the rising-tick edge; the slave changes miso only after sck falls.
- Reset mid-frame: immediately nss=1, sck=0, no done pulse; rx_data returns to 0.
- Bit counter width is $clog2(DATA_W+1); divider counter width is $clog2(CLK_DIV). The divider counter resets to 0 on every state entry.

Decomposition:
- spi_pkg: state enum (IDLE, SETUP, XFER, HOLD, GAP), SPI_DATA_W default constant, CPOL/CPHA mode localparams shared with the slave.
- Sub-module spi_clk_div: counter with enable and clear, one-cycle tick at terminal count. The FSM uses its ticks for both phase timing and sck toggling.

Test Plan:
1. Loopback (miso=mosi), DATA_W=16, CLK_DIV=4, tx_data=16'hA5C3 -> first sck rise at edge 4, last fall at edge 128, nss high at 132, done at 136, rx_data=16'hA5C3, busy high on edges 0-135.
2. tx_data=16'h8001 -> mosi sampled at the 16 sck rises reads 1,0×14,1; mosi never changes while sck=1.
3. Slave model driving 16'h3C5A on miso (changes after each sck fall) -> rx_data=16'h3C5A, done pulses exactly once.
4. start pulsed at edges 20 and 60 during a frame -> ignored: exactly 16 sck rises, one done.
5. start held high continuously -> back-to-back frames with nss high for exactly 4 cycles between frames; second frame's first rise at edge 140.
6. n_rst asserted at edge 50 mid-frame -> nss=1, sck=0, busy=0 asynchronously; no done pulse. A subsequent start with 16'h00FF completes correctly.
